tdc_interval_meter: RTL and testbench

- Downstream consumer of the two-channel thermometer-to-binary fine decoder.
- Combines each channel's 6-bit fine code with a free-running coarse counter to form start/stop timestamps and computes the start→stop interval.
- Delivers each result over a valid/ready handshake to the real-time feedback logic.
- Channel 1 is start, channel 2 is stop.

---
 rtl/tdc_pkg.sv | 20 ++
 rtl/tdc_interval_meter_if.sv | 12 +
 rtl/tdc_ts_former.sv | 41 ++++
 rtl/tdc_interval_meter.sv | 143 ++++++++++++++
 tb/tb_tdc_interval_meter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tdc_pkg.sv
// Shared constants, FSM state type and fine-code validation for the
// TDC interval meter.
package tdc_pkg;

  localparam int         FINE_W   = 6;
  localparam logic [5:0] FINE_MAX = 6'd40;   // largest code the decoder can legally produce
  localparam logic [5:0] FINE_TOP = 6'd63;   // sub-bin = FINE_TOP - code

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_STOP = 2'd1,
    EMIT      = 2'd2
  } tdc_state_t;

  // A code is a hit only if it is non-zero and within the legal range.
  function automatic logic fine_valid(input logic [FINE_W-1:0] code);
    return (code != '0) && (code <= FINE_MAX);
  endfunction

endpackage

// File: rtl/tdc_interval_meter_if.sv
// Result handshake (valid/ready) from the interval meter to the feedback logic.
interface tdc_interval_meter_if #(
  parameter int COARSE_W = 16
);
  logic                  res_valid;
  logic                  res_ready;
  logic [COARSE_W+5:0]   res_interval;
  logic                  res_timeout;

  modport master (output res_valid, output res_interval, output res_timeout, input res_ready);
  modport slave  (input res_valid, input res_interval, input res_timeout, output res_ready);
endinterface

// File: rtl/tdc_ts_former.sv
// Two-stage timestamp former: stage 1 registers the fine code together with
// the coarse count, stage 2 validates the code and forms {coarse, sub-bin}.
module tdc_ts_former
  import tdc_pkg::*;
#(
  parameter int COARSE_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [FINE_W-1:0]          fine,
  input  logic [COARSE_W-1:0]        coarse,
  output logic [COARSE_W+FINE_W-1:0] ts,
  output logic                       hit
);

  logic [FINE_W-1:0]   fine_q;
  logic [COARSE_W-1:0] coarse_q;

  // Stage 1: capture code and coarse count in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fine_q   <= '0;
      coarse_q <= '0;
    end else begin
      fine_q   <= fine;
      coarse_q <= coarse;
    end
  end

  // Stage 2: a larger code means an earlier edge, so invert it into a sub-bin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts  <= '0;
      hit <= 1'b0;
    end else begin
      ts  <= {coarse_q, FINE_TOP - fine_q};
      hit <= fine_valid(fine_q);
    end
  end

endmodule

// File: rtl/tdc_interval_meter.sv
// Start/stop interval meter built on two fine-code timestamp formers and a
// free-running coarse counter. Optional statistics counters are enabled by
// defining TDC_STATS_EN.
module tdc_interval_meter
  import tdc_pkg::*;
#(
  parameter int COARSE_W    = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arm,
  input  logic [FINE_W-1:0]   fine_start,
  input  logic [FINE_W-1:0]   fine_stop,
  tdc_interval_meter_if.master res,
`ifdef TDC_STATS_EN
  output logic [15:0]         drop_cnt,
  output logic [15:0]         timeout_cnt,
`endif
  output logic                busy
);

  localparam int IW = COARSE_W + FINE_W;
  localparam logic [COARSE_W-1:0] TMO_LAST = COARSE_W'(TIMEOUT_CYC - 1);

  logic [COARSE_W-1:0] coarse;
  logic [IW-1:0]       ts_start_in, ts_stop_in, ts_start, result_interval;
  logic                hit_start, hit_stop, result_timeout;
  logic [COARSE_W-1:0] tmo_cnt;
  tdc_state_t          state;
  logic                out_valid, out_timeout;
  logic [IW-1:0]       out_interval;
  logic                emit, load;

  // Free-running coarse counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coarse <= '0;
    else        coarse <= coarse + 1'b1;
  end

  tdc_ts_former #(.COARSE_W(COARSE_W)) u_ts_start (
    .clk(clk), .rst_n(rst_n), .fine(fine_start), .coarse(coarse),
    .ts(ts_start_in), .hit(hit_start)
  );

  tdc_ts_former #(.COARSE_W(COARSE_W)) u_ts_stop (
    .clk(clk), .rst_n(rst_n), .fine(fine_stop), .coarse(coarse),
    .ts(ts_stop_in), .hit(hit_stop)
  );

  // Measurement FSM: first start wins, stop or timeout produces a result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      ts_start        <= '0;
      tmo_cnt         <= '0;
      result_interval <= '0;
      result_timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arm && hit_start) begin
            ts_start <= ts_start_in;
            tmo_cnt  <= '0;
            // Same-cycle stop only counts if it is not earlier than the start.
            if (hit_stop && (ts_stop_in[FINE_W-1:0] >= ts_start_in[FINE_W-1:0])) begin
              result_interval <= ts_stop_in - ts_start_in;
              result_timeout  <= 1'b0;
              state           <= EMIT;
            end else begin
              state <= WAIT_STOP;
            end
          end
        end
        WAIT_STOP: begin
          if (!arm) begin
            state <= IDLE;
          end else if (hit_stop) begin
            result_interval <= ts_stop_in - ts_start;
            result_timeout  <= 1'b0;
            state           <= EMIT;
          end else if (tmo_cnt == TMO_LAST) begin
            result_interval <= '1;
            result_timeout  <= 1'b1;
            state           <= EMIT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        EMIT:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign emit = (state == EMIT);
  assign load = emit && (!out_valid || res.res_ready);

  // Output register: hold while stalled, drop a new result if still full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_interval <= '0;
      out_timeout  <= 1'b0;
    end else if (load) begin
      out_valid    <= 1'b1;
      out_interval <= result_interval;
      out_timeout  <= result_timeout;
    end else if (out_valid && res.res_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign res.res_valid    = out_valid;
  assign res.res_interval = out_interval;
  assign res.res_timeout  = out_timeout;
  assign busy             = (state == WAIT_STOP);

`ifdef TDC_STATS_EN
  logic arm_d;

  // Saturating drop/timeout counters, cleared on each arm rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_d       <= 1'b0;
      drop_cnt    <= '0;
      timeout_cnt <= '0;
    end else begin
      arm_d <= arm;
      if (arm && !arm_d) begin
        drop_cnt    <= '0;
        timeout_cnt <= '0;
      end else begin
        if (emit && !load && (drop_cnt != 16'hFFFF))
          drop_cnt <= drop_cnt + 1'b1;
        if (emit && result_timeout && (timeout_cnt != 16'hFFFF))
          timeout_cnt <= timeout_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tdc_interval_meter.sv
// Scoreboard bench for tdc_interval_meter: directed hits queue their expected
// results, a monitor pops and compares on every output transfer.
module tb_tdc_interval_meter;

  localparam int COARSE_W = 16;
  localparam int IW       = COARSE_W + 6;

  typedef struct packed {
    logic [IW-1:0] iv;
    logic          to;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0;
  logic [5:0]  fine_start = '0;
  logic [5:0]  fine_stop = '0;
  logic        busy;
`ifdef TDC_STATS_EN
  logic [15:0] drop_cnt, timeout_cnt;
`endif

  tdc_interval_meter_if #(.COARSE_W(COARSE_W)) res_if ();

  tdc_interval_meter #(.COARSE_W(COARSE_W), .TIMEOUT_CYC(1024)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .arm(arm),
    .fine_start(fine_start),
    .fine_stop(fine_stop),
    .res(res_if),
`ifdef TDC_STATS_EN
    .drop_cnt(drop_cnt),
    .timeout_cnt(timeout_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Coarse value the DUT counter holds between edges.
  logic [15:0] tb_coarse;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_coarse <= '0;
    else        tb_coarse <= tb_coarse + 16'd1;
  end

  // Monitor: every transfer must match the oldest queued expectation.
  always @(negedge clk) begin
    #2;
    if (rst_n && res_if.res_valid && res_if.res_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result actual interval=%0d timeout=%0d required no result",
                 res_if.res_interval, res_if.res_timeout);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (res_if.res_interval !== e.iv || res_if.res_timeout !== e.to) begin
          errors++;
          $display("FAIL result actual interval=%0d timeout=%0d required interval=%0d timeout=%0d",
                   res_if.res_interval, res_if.res_timeout, e.iv, e.to);
        end else begin
          $display("PASS result interval=%0d timeout=%0d", e.iv, e.to);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end else begin
      $display("PASS %s value=%0d", name, act);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_coarse(input logic [15:0] v);
    int n;
    n = 0;
    while (tb_coarse != v && n < 70000) begin
      @(negedge clk);
      n++;
    end
    if (tb_coarse != v) chk("wait_coarse_bound", 32'(tb_coarse), 32'(v));
  endtask

  // Present codes for exactly one sampling edge.
  task automatic hit(input logic [5:0] fs, input logic [5:0] fp);
    fine_start = fs;
    fine_stop  = fp;
    @(negedge clk);
    fine_start = '0;
    fine_stop  = '0;
  endtask

  task automatic wait_valid(input int limit);
    int n;
    n = 0;
    while (!res_if.res_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!res_if.res_valid) chk("wait_valid_bound", 32'(res_if.res_valid), 32'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((res_if.res_valid || busy) && n < 50) begin
      @(negedge clk);
      n++;
    end
    cycles(3);
  endtask

  initial begin
    res_if.res_ready = 1'b1;
    cycles(2);
    chk("reset_valid",    32'(res_if.res_valid),    32'd0);
    chk("reset_interval", 32'(res_if.res_interval), 32'd0);
    chk("reset_timeout",  32'(res_if.res_timeout),  32'd0);
    chk("reset_busy",     32'(busy),                32'd0);
    rst_n = 1'b1;
    cycles(2);
    arm = 1'b1;

    // Basic interval with latency check: 6625 - 6453 = 172.
    exp_q.push_back('{iv: IW'(172), to: 1'b0});
    wait_coarse(16'd100);
    hit(6'd10, 6'd0);
    wait_coarse(16'd103);
    chk("basic_busy", 32'(busy), 32'd1);
    hit(6'd0, 6'd30);
    cycles(2);
    chk("latency_not_early", 32'(res_if.res_valid), 32'd0);
    cycles(1);
    chk("latency_valid", 32'(res_if.res_valid), 32'd1);
    wait_drain();

    // Same-cycle, stop later in the cycle: 53 - 43 = 10.
    exp_q.push_back('{iv: IW'(10), to: 1'b0});
    wait_coarse(16'd200);
    hit(6'd20, 6'd10);
    wait_valid(10);
    wait_drain();

    // Same-cycle, stop earlier: ignored; later stop F=40 at 304 gives 226.
    wait_coarse(16'd300);
    hit(6'd10, 6'd20);
    cycles(2);
    chk("same_cycle_busy",  32'(busy),             32'd1);
    chk("same_cycle_valid", 32'(res_if.res_valid), 32'd0);
    exp_q.push_back('{iv: IW'(226), to: 1'b0});
    wait_coarse(16'd304);
    hit(6'd0, 6'd40);
    wait_valid(10);
    wait_drain();

    // Backpressure: A (64) held, B (39) dropped.
    res_if.res_ready = 1'b0;
    exp_q.push_back('{iv: IW'(64), to: 1'b0});
    wait_coarse(16'd400);
    hit(6'd1, 6'd0);
    wait_coarse(16'd401);
    hit(6'd0, 6'd1);
    wait_valid(10);
    cycles(3);
    chk("bp_hold_a", 32'(res_if.res_interval), 32'd64);
    wait_coarse(16'd500);
    hit(6'd40, 6'd1);
    cycles(6);
    chk("bp_hold_valid",    32'(res_if.res_valid),    32'd1);
    chk("bp_hold_interval", 32'(res_if.res_interval), 32'd64);
    chk("bp_hold_timeout",  32'(res_if.res_timeout),  32'd0);
`ifdef TDC_STATS_EN
    chk("drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    res_if.res_ready = 1'b1;
    cycles(3);
    chk("bp_single_transfer", 32'(res_if.res_valid), 32'd0);
    chk("bp_queue_empty",     32'(exp_q.size()),     32'd0);

    // Timeout: no stop for 1024 cycles.
    exp_q.push_back('{iv: {IW{1'b1}}, to: 1'b1});
    wait_coarse(16'd600);
    hit(6'd5, 6'd0);
    cycles(2);
    chk("timeout_busy", 32'(busy), 32'd1);
    wait_valid(1100);
    chk("timeout_busy_fall", 32'(busy), 32'd0);
`ifdef TDC_STATS_EN
    chk("timeout_cnt", 32'(timeout_cnt), 32'd1);
`endif
    wait_drain();

    // Abort via arm=0: no result.
    wait_coarse(16'd1800);
    hit(6'd7, 6'd0);
    cycles(2);
    chk("abort_busy_before", 32'(busy), 32'd1);
    arm = 1'b0;
    cycles(2);
    chk("abort_busy_after", 32'(busy), 32'd0);
    arm = 1'b1;
    cycles(8);
    chk("abort_no_result", 32'(res_if.res_valid), 32'd0);

    // Asynchronous reset mid-measurement.
    wait_coarse(16'd1900);
    hit(6'd7, 6'd0);
    cycles(2);
    chk("reset_mid_busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_busy",     32'(busy),                32'd0);
    chk("reset_mid_valid",    32'(res_if.res_valid),    32'd0);
    chk("reset_mid_interval", 32'(res_if.res_interval), 32'd0);
    chk("reset_mid_timeout",  32'(res_if.res_timeout),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(3);

    // Illegal code: no capture.
    hit(6'd50, 6'd0);
    cycles(4);
    chk("illegal_no_capture", 32'(busy), 32'd0);

    // Coarse wrap: start F=1 at 65535, stop F=1 at 2 -> 192.
    exp_q.push_back('{iv: IW'(192), to: 1'b0});
    wait_coarse(16'd65535);
    hit(6'd1, 6'd0);
    wait_coarse(16'd2);
    hit(6'd0, 6'd1);
    wait_valid(10);
    wait_drain();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
